// File: rtl/lcd_if_pkg.sv
// Shared definitions for the serial-RGB LCD timing generator and capture blocks.
package lcd_if_pkg;
  // Horizontal counts are in pixels, vertical counts are in lines.
  localparam int H_VISIBLE = 320;
  localparam int H_FRONT   = 20;
  localparam int H_SYNC    = 10;
  localparam int H_BACK    = 30;
  localparam int V_VISIBLE = 240;
  localparam int V_FRONT   = 4;
  localparam int V_SYNC    = 3;
  localparam int V_BACK    = 15;

  typedef enum logic [1:0] {CH_R = 2'd0, CH_G = 2'd1, CH_B = 2'd2} ch_e;
  typedef enum logic {SEARCH = 1'b0, FRAME = 1'b1} cap_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
endpackage

// File: rtl/lcd_rgb_capture_if.sv
// Serial-RGB byte stream in, tagged pixels and status out.
interface lcd_rgb_capture_if;
  logic [7:0]  lcd_dat;
  logic        lcd_hsync;
  logic        lcd_vsync;
  logic        lcd_den;
  logic        pix_valid;
  logic [23:0] pix_rgb;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic        frame_start;
  logic        locked;
  logic        err_align;
  logic        err_overrun;
  logic [15:0] frame_crc;

  modport master (
    output lcd_dat, lcd_hsync, lcd_vsync, lcd_den,
    input  pix_valid, pix_rgb, pix_x, pix_y, frame_start, locked,
           err_align, err_overrun, frame_crc
  );
  modport slave (
    input  lcd_dat, lcd_hsync, lcd_vsync, lcd_den,
    output pix_valid, pix_rgb, pix_x, pix_y, frame_start, locked,
           err_align, err_overrun, frame_crc
  );
endinterface

// File: rtl/crc16_ccitt_byte.sv
// Combinational CRC-16-CCITT advance by one byte, MSB first.
module crc16_ccitt_byte (
  input  logic [15:0] crc_i,
  input  logic [7:0]  dat_i,
  output logic [15:0] crc_o
);
  import lcd_if_pkg::*;

  logic [15:0] c;

  always_comb begin
    c = crc_i ^ {dat_i, 8'h00};
    for (int i = 0; i < 8; i++)
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    crc_o = c;
  end
endmodule

// File: rtl/lcd_rgb_capture.sv
// Serial-RGB LCD receiver: packs R,G,B bytes into tagged pixels and flags framing errors.
// Define CAPTURE_CRC_EN to get a per-frame CRC-16-CCITT on frame_crc.
module lcd_rgb_capture #(
  parameter int H_VISIBLE = lcd_if_pkg::H_VISIBLE,
  parameter int V_VISIBLE = lcd_if_pkg::V_VISIBLE
) (
  input  logic               clk,
  input  logic               resetn,
  lcd_rgb_capture_if.slave   cif
);
  import lcd_if_pkg::*;

  localparam logic [8:0] X_MAX = 9'(H_VISIBLE);
  localparam logic [7:0] Y_MAX = 8'(V_VISIBLE);

  cap_state_e  state_q, state_d;
  ch_e         chan_q, chan_d, ch;
  logic [8:0]  x_q, x_d, px_q, px_d;
  logic [7:0]  y_q, y_d, py_q, py_d;
  logic [7:0]  r_q, r_d, g_q, g_d;
  logic [23:0] rgb_q, rgb_d;
  logic        pv_q, pv_d, fs_q, fs_d;
  logic        ea_q, ea_d, eo_q, eo_d, sup_q, sup_d;
  logic        vs_q, den_q, hs_q;
  logic        vs_fall, den_fall, den_rise, hs_fall;

  assign vs_fall  = vs_q & ~cif.lcd_vsync;
  assign den_fall = den_q & ~cif.lcd_den;
  assign den_rise = ~den_q & cif.lcd_den;
  assign hs_fall  = hs_q & ~cif.lcd_hsync;

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    ch      = chan_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    g_d     = g_q;
    rgb_d   = rgb_q;
    px_d    = px_q;
    py_d    = py_q;
    pv_d    = 1'b0;
    fs_d    = 1'b0;
    ea_d    = ea_q;
    eo_d    = eo_q;
    sup_d   = sup_q;
    if (vs_fall) begin
      // Same handling in both states; a byte arriving with the edge is dropped.
      state_d = FRAME;
      fs_d    = 1'b1;
      x_d     = '0;
      y_d     = '0;
      chan_d  = CH_R;
      sup_d   = 1'b0;
    end else if (state_q == FRAME) begin
      if (hs_fall && !cif.lcd_den) ea_d = 1'b1;
      if (!cif.lcd_den) begin
        ch = den_fall ? CH_R : chan_q;
        if (den_fall && (y_q == Y_MAX)) begin
          eo_d  = 1'b1;
          sup_d = 1'b1;
        end
        unique case (ch)
          CH_R: begin r_d = cif.lcd_dat; chan_d = CH_G; end
          CH_G: begin g_d = cif.lcd_dat; chan_d = CH_B; end
          default: begin
            chan_d = CH_R;
            if (sup_q) begin
              // frame already overran: keep discarding
            end else if (x_q == X_MAX) begin
              eo_d = 1'b1;
            end else begin
              pv_d  = 1'b1;
              rgb_d = {r_q, g_q, cif.lcd_dat};
              px_d  = x_q;
              py_d  = y_q;
              x_d   = x_q + 9'd1;
            end
          end
        endcase
      end else if (den_rise) begin
        if (chan_q != CH_R) ea_d = 1'b1;
        if (x_q != '0) y_d = y_q + 8'd1;
        x_d    = '0;
        chan_d = CH_R;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= SEARCH;
      chan_q  <= CH_R;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      g_q     <= '0;
      rgb_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pv_q    <= 1'b0;
      fs_q    <= 1'b0;
      ea_q    <= 1'b0;
      eo_q    <= 1'b0;
      sup_q   <= 1'b0;
      vs_q    <= 1'b0;
      den_q   <= 1'b0;
      hs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      g_q     <= g_d;
      rgb_q   <= rgb_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pv_q    <= pv_d;
      fs_q    <= fs_d;
      ea_q    <= ea_d;
      eo_q    <= eo_d;
      sup_q   <= sup_d;
      vs_q    <= cif.lcd_vsync;
      den_q   <= cif.lcd_den;
      hs_q    <= cif.lcd_hsync;
    end
  end

  assign cif.pix_valid   = pv_q;
  assign cif.pix_rgb     = rgb_q;
  assign cif.pix_x       = px_q;
  assign cif.pix_y       = py_q;
  assign cif.frame_start = fs_q;
  assign cif.locked      = (state_q == FRAME);
  assign cif.err_align   = ea_q;
  assign cif.err_overrun = eo_q;

`ifdef CAPTURE_CRC_EN
  logic        byte_ok;
  logic [15:0] crc_q, crc_nxt, fcrc_q;

  assign byte_ok = (state_q == FRAME) && !vs_fall && !cif.lcd_den;

  crc16_ccitt_byte u_crc (.crc_i(crc_q), .dat_i(cif.lcd_dat), .crc_o(crc_nxt));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      crc_q  <= CRC_INIT;
      fcrc_q <= '0;
    end else if (vs_fall) begin
      fcrc_q <= crc_q;
      crc_q  <= CRC_INIT;
    end else if (byte_ok) begin
      crc_q  <= crc_nxt;
    end
  end

  assign cif.frame_crc = fcrc_q;
`else
  assign cif.frame_crc = 16'h0000;
`endif
endmodule

// File: tb/tb_lcd_rgb_capture.sv
// Scoreboard bench for lcd_rgb_capture on a reduced 8x4 raster.
module tb_lcd_rgb_capture;
  localparam int H = 8;
  localparam int V = 4;
`ifdef CAPTURE_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  lcd_rgb_capture_if cif();
  lcd_rgb_capture #(.H_VISIBLE(H), .V_VISIBLE(V)) dut (.clk(clk), .resetn(resetn), .cif(cif));

  int n_cmp = 0;
  int n_bad = 0;
  int fs_cnt = 0;
  int pix_cnt = 0;
  logic [40:0] exp_q[$];
  logic        m_prev_vs = 1'b1;
  logic        m_locked = 1'b0;
  logic [15:0] m_run = 16'hFFFF;
  logic [15:0] m_fcrc = 16'h0000;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Bit-serial reference CRC-16-CCITT.
  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ b[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  // One byte time: score last cycle's outputs, update the model, drive new inputs.
  task automatic step(input logic [7:0] d, input logic den_n, input logic hs, input logic vs);
    logic [40:0] e;
    @(negedge clk);
    if (cif.pix_valid === 1'b1) begin
      pix_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pix_unexpected: got rgb=%h x=%0d y=%0d, required no pixel", cif.pix_rgb, cif.pix_x, cif.pix_y);
      end else begin
        e = exp_q.pop_front();
        if ({cif.pix_rgb, cif.pix_x, cif.pix_y} !== e) begin
          n_bad++;
          $display("FAIL pix_data: got %h/%0d/%0d, required %h/%0d/%0d", cif.pix_rgb, cif.pix_x, cif.pix_y, e[40:17], e[16:8], e[7:0]);
        end
      end
      n_cmp++;
      if (cif.pix_x >= 9'(H)) begin
        n_bad++;
        $display("FAIL pix_x_range: got %0d, required < %0d", cif.pix_x, H);
      end
    end
    if (cif.frame_start === 1'b1) fs_cnt++;
    if (m_prev_vs && !vs) begin
      m_fcrc   = m_run;
      m_run    = 16'hFFFF;
      m_locked = 1'b1;
    end else if (m_locked && !den_n) begin
      m_run = crc_bit(m_run, d);
    end
    m_prev_vs     = vs;
    cif.lcd_dat   = d;
    cif.lcd_den   = den_n;
    cif.lcd_hsync = hs;
    cif.lcd_vsync = vs;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b1, !(i == 2 || i == 3), 1'b1);
  endtask

  task automatic vsync_pulse();
    step(8'h00, 1'b1, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1, 1'b1);
  endtask

  // npix pixels on row y; the first nexp are expected at the output.
  task automatic send_line(input int npix, input int y, input int nexp, input bit zero);
    for (int p = 0; p < npix; p++) begin
      logic [7:0] r, g, b;
      r = zero ? 8'h00 : 8'(p);
      g = zero ? 8'h00 : 8'(y);
      b = zero ? 8'h00 : 8'hA5;
      step(r, 1'b0, 1'b1, 1'b1);
      step(g, 1'b0, 1'b1, 1'b1);
      if (p < nexp) exp_q.push_back({r, g, b, 9'(p), 8'(y)});
      step(b, 1'b0, 1'b1, 1'b1);
    end
    blank(6);
  endtask

  task automatic model_reset();
    m_locked  = 1'b0;
    m_run     = 16'hFFFF;
    m_fcrc    = 16'h0000;
    m_prev_vs = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    cif.lcd_dat = 8'h00; cif.lcd_den = 1'b1; cif.lcd_hsync = 1'b1; cif.lcd_vsync = 1'b1;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cif.pix_valid, cif.frame_start, cif.locked, cif.err_align, cif.err_overrun} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b, required 00000", {cif.pix_valid, cif.frame_start, cif.locked, cif.err_align, cif.err_overrun});
    end
    n_cmp++;
    if ({cif.pix_rgb, cif.pix_x, cif.pix_y} !== 41'd0) begin
      n_bad++; $display("FAIL reset_pix: got %h/%0d/%0d, required 0/0/0", cif.pix_rgb, cif.pix_x, cif.pix_y);
    end
    n_cmp++;
    if (cif.frame_crc !== 16'h0000) begin
      n_bad++; $display("FAIL reset_crc: got %h, required 0000", cif.frame_crc);
    end
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_search();
    blank(3);
    for (int i = 0; i < 3; i++) begin
      step(8'h5A, 1'b0, 1'b1, 1'b1);
      step(8'hC3, 1'b0, 1'b1, 1'b1);
      step(8'h3C, 1'b0, 1'b1, 1'b1);
      step(8'h00, 1'b1, 1'b1, 1'b1);
    end
    step(8'h00, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (cif.locked !== 1'b0) begin n_bad++; $display("FAIL search_locked: got %b, required 0", cif.locked); end
    step(8'h00, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (cif.locked !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %b, required 0", cif.locked); end
    step(8'h00, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (cif.locked !== 1'b1) begin n_bad++; $display("FAIL lock_after_vs: got %b, required 1", cif.locked); end
    n_cmp++;
    if (cif.frame_start !== 1'b1) begin n_bad++; $display("FAIL frame_start_pulse: got %b, required 1", cif.frame_start); end
    step(8'h00, 1'b1, 1'b1, 1'b1);
    blank(2);
    n_cmp++;
    if (cif.frame_start !== 1'b0) begin n_bad++; $display("FAIL frame_start_width: got %b, required 0", cif.frame_start); end
    n_cmp++;
    if (cif.frame_crc !== (CRC_ON ? m_fcrc : 16'h0000)) begin
      n_bad++; $display("FAIL crc_first_vs: got %h, required %h", cif.frame_crc, CRC_ON ? m_fcrc : 16'h0000);
    end
  endtask

  task automatic test_frame(input bit zero);
    int fs0, pc0;
    fs0 = fs_cnt;
    pc0 = pix_cnt;
    for (int y = 0; y < V; y++) send_line(H, y, H, zero);
    n_cmp++;
    if (pix_cnt - pc0 != H * V) begin n_bad++; $display("FAIL frame_pix_count: got %0d, required %0d", pix_cnt - pc0, H * V); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL frame_pix_missing: got %0d pending, required 0", exp_q.size()); end
    n_cmp++;
    if ({cif.err_align, cif.err_overrun} !== 2'b00) begin
      n_bad++; $display("FAIL frame_errors: got %b, required 00", {cif.err_align, cif.err_overrun});
    end
    vsync_pulse();
    blank(2);
    n_cmp++;
    if (fs_cnt - fs0 != 1) begin n_bad++; $display("FAIL frame_start_count: got %0d, required 1", fs_cnt - fs0); end
    n_cmp++;
    if (cif.frame_crc !== (CRC_ON ? m_fcrc : 16'h0000)) begin
      n_bad++; $display("FAIL frame_crc (zero=%0d): got %h, required %h", zero, cif.frame_crc, CRC_ON ? m_fcrc : 16'h0000);
    end
  endtask

  task automatic test_align();
    step(8'h11, 1'b0, 1'b1, 1'b1);
    step(8'h22, 1'b0, 1'b1, 1'b1);
    exp_q.push_back({24'h112233, 9'd0, 8'd0});
    step(8'h33, 1'b0, 1'b1, 1'b1);
    step(8'h44, 1'b0, 1'b1, 1'b1);
    blank(6);
    n_cmp++;
    if (cif.err_align !== 1'b1) begin n_bad++; $display("FAIL align_err: got %b, required 1", cif.err_align); end
    n_cmp++;
    if (cif.err_overrun !== 1'b0) begin n_bad++; $display("FAIL align_no_overrun: got %b, required 0", cif.err_overrun); end
    send_line(1, 1, 1, 1'b0);
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL align_pix_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_x_overrun();
    send_line(H + 1, 2, H, 1'b0);
    n_cmp++;
    if (cif.err_overrun !== 1'b1) begin n_bad++; $display("FAIL x_overrun_err: got %b, required 1", cif.err_overrun); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL x_overrun_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midline();
    vsync_pulse();
    for (int p = 0; p < 3; p++) begin
      step(8'(p), 1'b0, 1'b1, 1'b1);
      step(8'h00, 1'b0, 1'b1, 1'b1);
      exp_q.push_back({8'(p), 8'h00, 8'hA5, 9'(p), 8'd0});
      step(8'hA5, 1'b0, 1'b1, 1'b1);
    end
    step(8'h03, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cif.pix_valid, cif.frame_start, cif.locked, cif.err_align, cif.err_overrun} !== 5'b0) begin
      n_bad++; $display("FAIL midreset_flags: got %b, required 00000", {cif.pix_valid, cif.frame_start, cif.locked, cif.err_align, cif.err_overrun});
    end
    n_cmp++;
    if ({cif.pix_rgb, cif.pix_x, cif.pix_y, cif.frame_crc} !== 57'd0) begin
      n_bad++; $display("FAIL midreset_outputs: got %h/%0d/%0d/%h, required all 0", cif.pix_rgb, cif.pix_x, cif.pix_y, cif.frame_crc);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL midreset_pending: got %0d, required 0", exp_q.size()); end
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) step(8'h77, 1'b0, 1'b1, 1'b1);
    blank(6);
    send_line(H, 1, 0, 1'b0);
    n_cmp++;
    if (cif.locked !== 1'b0) begin n_bad++; $display("FAIL midreset_locked: got %b, required 0", cif.locked); end
    vsync_pulse();
    send_line(2, 0, 2, 1'b0);
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL midreset_resume: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_y_overrun();
    for (int y = 1; y < V; y++) send_line(H, y, H, 1'b0);
    n_cmp++;
    if (cif.err_overrun !== 1'b0) begin n_bad++; $display("FAIL y_full_no_err: got %b, required 0", cif.err_overrun); end
    send_line(2, V, 0, 1'b0);
    n_cmp++;
    if (cif.err_overrun !== 1'b1) begin n_bad++; $display("FAIL y_overrun_err: got %b, required 1", cif.err_overrun); end
    n_cmp++;
    if (cif.locked !== 1'b1) begin n_bad++; $display("FAIL y_overrun_locked: got %b, required 1", cif.locked); end
  endtask

  initial begin
    test_reset();
    test_search();
    test_frame(1'b0);
    test_frame(1'b1);
    test_align();
    test_x_overrun();
    test_reset_midline();
    test_y_overrun();
    blank(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lcd_rgb_capture.md
Name: lcd_rgb_capture

Overview:
- Receive side of the 8-bit serial-RGB LCD interface; consumes the lcd_dat/lcd_hsync/lcd_vsync/lcd_den stream that the LCD timing generator produces.
- Reassembles three consecutive bytes (R, G, B) into one 24-bit pixel and tags it with its x/y coordinate.
- Flags framing errors.
- Used for on-badge loopback self-test and for capturing frames from an external panel-format source.
- Runs on the same 19.2 MHz pixel clock as the generator (one byte per clk).

Parameters:
- H_VISIBLE, 320, pixels per active line
- V_VISIBLE, 240, active lines per frame

Ports:
- clk  in  1  pixel/byte clock
- resetn  in  1  reset, synchronous, active-low
- lcd_dat  in  8  serial colour byte
- lcd_hsync  in  1  line sync, active-low
- lcd_vsync  in  1  frame sync, active-low
- lcd_den  in  1  data enable, active-low (low = byte is visible data)
- pix_valid  out  1  one-cycle strobe: pix_rgb/pix_x/pix_y are valid
- pix_rgb  out  24  {R,G,B}
- pix_x  out  9  column 0..H_VISIBLE-1
- pix_y  out  8  row 0..V_VISIBLE-1
- frame_start  out  1  one-cycle pulse on vsync falling edge
- locked  out  1  high while in FRAME state
- err_align  out  1  sticky: active run not a multiple of 3 bytes
- err_overrun  out  1  sticky: more than H_VISIBLE pixels in a line, or more than V_VISIBLE lines in a frame
- frame_crc  out  16  CRC of the previous frame (see Optional Feature)

Behaviour:
- All inputs are sampled on posedge clk and are already synchronous; there is no CDC. Previous-cycle copies of vsync and den drive edge detection.
- Reset (resetn=0 at posedge):
  - state=SEARCH; all outputs 0.
  - Sticky errors cleared.
  - Channel counter, x and y counters all 0.
- State SEARCH:
  - Ignore data.
  - On vsync falling edge (prev=1, cur=0): go to FRAME, pulse frame_start, y=0, x=0, chan=0.
- State FRAME (locked=1):
  - Each cycle with den=0: store lcd_dat into the R/G/B byte selected by chan (0=R [23:16], 1=G [15:8], 2=B [7:0]), then advance chan 0→1→2→0.
  - When B is stored: on the next clk, pix_valid=1, pix_rgb holds the assembled pixel, pix_x=x, pix_y=y. Then x increments. Latency is 1 clk from B sampled to pix_valid.
  - pix_rgb/pix_x/pix_y hold their values when pix_valid=0.
  - A den falling edge forces chan=0, so alignment restarts on every line.
  - Den rising edge (end of active run):
    - If chan≠0, set err_align and drop the partial pixel.
    - If x>0, y increments.
    - x resets to 0 and chan to 0.
  - If x==H_VISIBLE and a further B completes: set err_overrun, suppress pix_valid, do not wrap x.
  - If y==V_VISIBLE and a further line starts: set err_overrun, suppress pixels until the next vsync falling edge.
  - A vsync falling edge in FRAME restarts the frame: frame_start pulse, x=y=chan=0, any partial pixel dropped.
  - If den=0 and a vsync falling edge occur in the same cycle, the vsync handling wins and the byte is discarded.
  - hsync is used for monitoring only: if hsync falls while den=0, set err_align.
- Sticky errors clear only on reset.
- Reset mid-frame returns to SEARCH; output resumes at the next vsync falling edge.

Optional Feature:
- Macro CAPTURE_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, 8 bits per clk) over every accepted data byte in the frame.
  - On each vsync falling edge, frame_crc latches the running value and the running CRC re-inits to 0xFFFF.
  - frame_crc resets to 0.
- Undefined: frame_crc tied to 16'h0000; no CRC logic synthesized.

Decomposition:
- Shared package lcd_if_pkg holds:
  - timing constants (H_VISIBLE/H_FRONT/H_SYNC/H_BACK, V_* equivalents)
  - byte-channel enum (CH_R=0, CH_G=1, CH_B=2)
  - capture state enum (SEARCH, FRAME)
  - CRC polynomial/init constants
- The same package is used by the generator.
- One sub-module, crc16_ccitt_byte (combinational next-CRC from crc+byte), instantiated only under CAPTURE_CRC_EN.

Test Plan:
- Loopback from the timing generator with rgb_data={x[7:0],y,8'hA5} → 76800 pix_valid per frame; each pixel matches its coordinates; frame_start once per 262-line frame; no errors.
- Data before the first vsync (den toggling while in SEARCH) → no pix_valid, locked=0; locked=1 on the cycle after the vsync falling edge.
- Active run of 4 bytes (0x11,0x22,0x33,0x44) → one pixel 0x112233 at x=0; err_align=1; next line starts at chan=0.
- Line of 321 pixels → pixels 0..319 output; 321st suppressed; err_overrun=1; pix_x never exceeds 319.
- resetn=0 for 1 clk mid-line at x=100 → all outputs 0, no pix_valid until the next vsync falling edge; first pixel then at (0,0).
- CAPTURE_CRC_EN with a frame where every byte is 0x00 → frame_crc equals the golden CRC-16-CCITT of 230400 zero bytes at the next vsync; without the macro, frame_crc stays 0x0000.
